// File: rtl/core_sequencer.sv
// core_sequencer: program counter, ALU flag registers with zero-flag history,
// branch-condition evaluation and the run/stall/done handshake of the core.
// Optional performance counters are compiled in when CORE_SEQ_PERF_EN is defined.
module core_sequencer #(
    parameter int D      = 12,
    parameter int HIST   = 2,
    parameter int END_PC = 400,
    parameter int RELW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            halt,
    input  logic            branch,
    input  logic [1:0]      cond,
    input  logic            rel_en,
    input  logic [D-1:0]    target,
    input  logic [RELW-1:0] offset,
    input  logic            flag_we,
    input  logic            zero_in,
    input  logic            neg_in,
    input  logic            carry_in,
    output logic [D-1:0]    prog_ctr,
    output logic            busy,
    output logic            done,
    output logic            taken,
    output logic            carry_q
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [15:0]     branch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [D-1:0]    pc_q;
    logic            busy_q;
    logic            done_q;
    logic            neg_q;
    logic [HIST-1:0] zhist_q;

    logic            condMet;
    logic [D-1:0]    pcStep_d;
    logic [HIST-1:0] zhistShift_d;

    assign prog_ctr = pc_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Branch decision and the PC/zero-history values a RUN cycle would load;
    // flags come only from already-registered state, never this cycle's ALU.
    always_comb begin
        condMet      = 1'b0;
        pcStep_d     = pc_q + D'(1);
        zhistShift_d = zhist_q;
        case (cond)
            2'b00:   condMet = &zhist_q;
            2'b01:   condMet = neg_q;
            2'b10:   condMet = !neg_q && !zhist_q[0];
            default: condMet = 1'b1;
        endcase
        taken = branch && (state_q == RUN) && !stall && condMet;
        if (taken && !rel_en) begin
            pcStep_d = target;
        end else if (taken) begin
            pcStep_d = pc_q + D'($signed(offset));
        end
        for (int i = HIST - 1; i > 0; i--) begin
            zhistShift_d[i] = zhist_q[i-1];
        end
        zhistShift_d[0] = zero_in;
    end

    // Sequencer FSM with registered PC, flags and handshake outputs; a start
    // pulse restarts from PC 0 in every state and clears the zero history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            zhist_q <= '0;
        end else if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            zhist_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall) begin
                        state_q <= STALL;
                    end else begin
                        if (flag_we) begin
                            zhist_q <= zhistShift_d;
                            neg_q   <= neg_in;
                            carry_q <= carry_in;
                        end
                        if (halt || (pc_q == D'(END_PC))) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q <= pcStep_d;
                        end
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CORE_SEQ_PERF_EN
    // Saturating activity counters; they stop moving once the program is done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt  <= '0;
            branch_cnt <= '0;
        end else if (start) begin
            cycle_cnt  <= '0;
            branch_cnt <= '0;
        end else begin
            if (((state_q == RUN) || (state_q == STALL)) && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (taken && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: vector table, hand-written corner sequences
// and randomized stimulus against a behavioural model.
module tb_core_sequencer;

    localparam int D      = 12;
    localparam int HIST   = 2;
    localparam int END_PC = 400;
    localparam int RELW   = 8;
    localparam int PC_MOD = 4096;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        bit        st;
        bit        sl;
        bit        hl;
        bit        br;
        bit [1:0]  cd;
        bit        re;
        bit [11:0] tg;
        bit [7:0]  of;
        bit        fw;
        bit        z;
        bit        n;
        bit        c;
    } stim_t;

    typedef struct {
        stim_t s;
        bit    expTaken;
        int    expPc;
        bit    expCarry;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            stall = 1'b0;
    logic            halt = 1'b0;
    logic            branch = 1'b0;
    logic [1:0]      cond = 2'b00;
    logic            rel_en = 1'b0;
    logic [D-1:0]    target = '0;
    logic [RELW-1:0] offset = '0;
    logic            flag_we = 1'b0;
    logic            zero_in = 1'b0;
    logic            neg_in = 1'b0;
    logic            carry_in = 1'b0;
    logic [D-1:0]    prog_ctr;
    logic            busy;
    logic            done;
    logic            taken;
    logic            carry_q;
`ifdef CORE_SEQ_PERF_EN
    logic [31:0]     cycleCnt;
    logic [15:0]     branchCnt;
`endif

    int total = 0;
    int bad = 0;

    // behavioural model state
    int mState;
    int mPc;
    bit mZ[$];
    bit mNeg;
    bit mCarry;

    vec_t tbl[31];

    core_sequencer #(.D(D), .HIST(HIST), .END_PC(END_PC), .RELW(RELW)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch(branch), .cond(cond), .rel_en(rel_en), .target(target),
        .offset(offset), .flag_we(flag_we), .zero_in(zero_in), .neg_in(neg_in),
        .carry_in(carry_in), .prog_ctr(prog_ctr), .busy(busy), .done(done),
        .taken(taken), .carry_q(carry_q)
`ifdef CORE_SEQ_PERF_EN
        , .cycle_cnt(cycleCnt), .branch_cnt(branchCnt)
`endif
    );

    // free-running clock
    always #5 clk = ~clk;

    function automatic stim_t mk(bit st, bit sl, bit hl, bit br, bit [1:0] cd, bit re,
                                 int tg, int of, bit fw, bit z, bit n, bit c);
        stim_t s;
        s.st = st; s.sl = sl; s.hl = hl; s.br = br; s.cd = cd; s.re = re;
        s.tg = 12'(tg); s.of = 8'(of); s.fw = fw; s.z = z; s.n = n; s.c = c;
        return s;
    endfunction

    function automatic vec_t mkv(stim_t s, bit t, int pc, bit c);
        vec_t v;
        v.s = s; v.expTaken = t; v.expPc = pc; v.expCarry = c;
        return v;
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int ePc, input bit eBusy,
                               input bit eDone, input bit eCarry);
        checkVal({tag, "Pc"}, int'(prog_ctr), ePc);
        checkVal({tag, "Busy"}, int'(busy), int'(eBusy));
        checkVal({tag, "Done"}, int'(done), int'(eDone));
        checkVal({tag, "Carry"}, int'(carry_q), int'(eCarry));
    endtask

    task automatic applyStimulus(input stim_t s);
        start = s.st; stall = s.sl; halt = s.hl; branch = s.br; cond = s.cd;
        rel_en = s.re; target = s.tg; offset = s.of; flag_we = s.fw;
        zero_in = s.z; neg_in = s.n; carry_in = s.c;
    endtask

    // drive one instruction, sample the combinational taken mid-cycle,
    // then step past the rising edge
    task automatic cycle(input stim_t s, output bit tkn);
        applyStimulus(s);
        #3;
        tkn = taken;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mState = M_IDLE;
        mPc = 0;
        mZ = {};
        for (int i = 0; i < HIST; i++) mZ.push_back(1'b0);
        mNeg = 1'b0;
        mCarry = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();
    endtask

    function automatic bit modelTaken(stim_t s);
        bit allZero;
        if (mState != M_RUN || !s.br || s.sl) return 1'b0;
        case (s.cd)
            2'd0: begin
                allZero = 1'b1;
                foreach (mZ[i]) if (!mZ[i]) allZero = 1'b0;
                return allZero;
            end
            2'd1: return mNeg;
            2'd2: return !mNeg && !mZ[0];
            default: return 1'b1;
        endcase
    endfunction

    task automatic modelUpdate(stim_t s, bit tk);
        int off;
        if (s.st) begin
            mState = M_RUN;
            mPc = 0;
            foreach (mZ[i]) mZ[i] = 1'b0;
        end else if (mState == M_STALL) begin
            if (!s.sl) mState = M_RUN;
        end else if (mState == M_RUN) begin
            if (s.sl) begin
                mState = M_STALL;
            end else begin
                if (s.fw) begin
                    mZ.push_front(s.z);
                    void'(mZ.pop_back());
                    mNeg = s.n;
                    mCarry = s.c;
                end
                if (s.hl || mPc == END_PC) begin
                    mState = M_DONE;
                end else if (tk && s.re) begin
                    off = int'(s.of);
                    if (off >= 128) off -= 256;
                    mPc = ((mPc + off) % PC_MOD + PC_MOD) % PC_MOD;
                end else if (tk) begin
                    mPc = int'(s.tg);
                end else begin
                    mPc = (mPc + 1) % PC_MOD;
                end
            end
        end
    endtask

    initial begin
        bit tk;
        stim_t s;

        // EQ/NEG/POS branches, relative wrap and restart, from a fresh reset
        tbl[0]  = mkv(mk(1,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        tbl[1]  = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 1, 0);
        tbl[2]  = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 2, 0);
        tbl[3]  = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 3, 0);
        tbl[4]  = mkv(mk(0,0,0,0,0,0,0,0,1,1,0,0), 0, 4, 0);
        tbl[5]  = mkv(mk(0,0,0,0,0,0,0,0,1,1,0,0), 0, 5, 0);
        tbl[6]  = mkv(mk(0,0,0,1,0,0,'h20,0,0,0,0,0), 1, 'h20, 0);
        tbl[7]  = mkv(mk(1,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        tbl[8]  = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 1, 0);
        tbl[9]  = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 2, 0);
        tbl[10] = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 3, 0);
        tbl[11] = mkv(mk(0,0,0,0,0,0,0,0,1,0,0,0), 0, 4, 0);
        tbl[12] = mkv(mk(0,0,0,0,0,0,0,0,1,1,0,0), 0, 5, 0);
        tbl[13] = mkv(mk(0,0,0,1,0,0,'h20,0,0,0,0,0), 0, 6, 0);
        tbl[14] = mkv(mk(1,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        tbl[15] = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 1, 0);
        tbl[16] = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 2, 0);
        tbl[17] = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 3, 0);
        tbl[18] = mkv(mk(0,0,0,1,3,1,0,'hFB,0,0,0,0), 1, 'hFFE, 0);
        tbl[19] = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 'hFFF, 0);
        tbl[20] = mkv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        tbl[21] = mkv(mk(0,0,0,1,1,0,'h100,0,0,0,0,0), 0, 1, 0);
        tbl[22] = mkv(mk(0,0,0,0,0,0,0,0,1,0,1,1), 0, 2, 1);
        tbl[23] = mkv(mk(0,0,0,1,1,0,'h100,0,0,0,0,0), 1, 'h100, 1);
        tbl[24] = mkv(mk(0,0,0,1,2,0,'h10,0,0,0,0,0), 0, 'h101, 1);
        tbl[25] = mkv(mk(0,0,0,0,0,0,0,0,1,0,0,0), 0, 'h102, 0);
        tbl[26] = mkv(mk(0,0,0,1,2,0,7,0,0,0,0,0), 1, 7, 0);
        tbl[27] = mkv(mk(0,0,0,1,2,1,0,'h10,0,0,0,0), 1, 'h17, 0);
        tbl[28] = mkv(mk(0,0,0,0,0,0,0,0,1,1,0,0), 0, 'h18, 0);
        tbl[29] = mkv(mk(0,0,0,1,2,0,'h50,0,0,0,0,0), 0, 'h19, 0);
        tbl[30] = mkv(mk(0,0,0,1,0,0,'h50,0,0,0,0,0), 0, 'h1A, 0);

        doReset();
        checkOutput("reset", 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) begin
            cycle(tbl[i].s, tk);
            checkVal($sformatf("tblTaken%0d", i), int'(tk), int'(tbl[i].expTaken));
            checkOutput($sformatf("tbl%0d", i), tbl[i].expPc, 1, 0, tbl[i].expCarry);
        end

        // basic run to END_PC, then DONE holds against noise
        doReset();
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0,0), tk);
        checkOutput("basicStart", 0, 1, 0, 0);
        for (int p = 1; p <= END_PC; p++) begin
            cycle(mk(0,0,0,0,0,0,0,0,0,0,0,0), tk);
            checkVal("basicPc", int'(prog_ctr), p);
        end
        cycle(mk(0,0,0,0,0,0,0,0,0,0,0,0), tk);
        checkOutput("basicEnd", END_PC, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(mk(0,1,1,1,3,0,5,0,1,1,1,1), tk);
            checkVal("doneTaken", int'(tk), 0);
            checkOutput("doneHold", END_PC, 0, 1, 0);
        end

        // stall freezes PC and flags while flag_we is active
        doReset();
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0,0), tk);
        for (int p = 0; p < 10; p++) begin
            cycle(mk(0,0,0,0,0,0,0,0,(p >= 8),1,0,0), tk);
        end
        checkVal("stallPrePc", int'(prog_ctr), 10);
        for (int k = 0; k < 3; k++) begin
            cycle(mk(0,1,0,1,3,0,'h77,0,1,k[0],1,1), tk);
            checkVal("stallTaken", int'(tk), 0);
            checkOutput("stallHold", 10, 1, 0, 0);
        end
        cycle(mk(0,0,0,0,0,0,0,0,0,0,0,0), tk);
        checkOutput("stallExit", 10, 1, 0, 0);
        cycle(mk(0,0,0,1,0,1,0,1,0,0,0,0), tk);
        checkVal("stallEqTaken", int'(tk), 1);
        checkVal("stallAfterPc", int'(prog_ctr), 11);
        cycle(mk(0,0,0,1,1,1,0,1,0,0,0,0), tk);
        checkVal("stallNegTaken", int'(tk), 0);
        checkOutput("stallNeg", 12, 1, 0, 0);

        // halt beats branch, restart from DONE, stall beats halt
        doReset();
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0,0), tk);
        for (int p = 0; p < 7; p++) cycle(mk(0,0,0,0,0,0,0,0,0,0,0,0), tk);
        cycle(mk(0,0,1,1,3,0,'h40,0,0,0,0,0), tk);
        checkOutput("haltBr", 7, 0, 1, 0);
        cycle(mk(0,0,1,1,3,0,'h40,0,0,0,0,0), tk);
        checkOutput("haltHold", 7, 0, 1, 0);
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0,0), tk);
        checkOutput("haltRestart", 0, 1, 0, 0);
        for (int p = 0; p < 3; p++) cycle(mk(0,0,0,0,0,0,0,0,0,0,0,0), tk);
        cycle(mk(0,1,1,0,0,0,0,0,0,0,0,0), tk);
        checkOutput("stallHalt", 3, 1, 0, 0);
        cycle(mk(0,0,1,0,0,0,0,0,0,0,0,0), tk);
        checkOutput("stallHaltExit", 3, 1, 0, 0);
        cycle(mk(0,0,1,0,0,0,0,0,0,0,0,0), tk);
        checkOutput("haltResample", 3, 0, 1, 0);

        // asynchronous reset between clock edges
        doReset();
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0,0), tk);
        for (int p = 0; p < 50; p++) cycle(mk(0,0,0,0,0,0,0,0,(p == 20),0,0,1), tk);
        checkOutput("preAsync", 50, 1, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async", 0, 0, 0, 0);
`ifdef CORE_SEQ_PERF_EN
        checkVal("asyncCycleCnt", int'(cycleCnt), 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();

        // randomized traffic against the behavioural model
        doReset();
        for (int n = 0; n < 4000; n++) begin
            bit expTk;
            s = mk(($urandom % 60) == 0, ($urandom % 5) == 0, ($urandom % 50) == 0, 0,
                   2'($urandom), 1'($urandom), int'($urandom % PC_MOD), int'($urandom % 256),
                   1'($urandom), ($urandom % 4) != 0, 1'($urandom), 1'($urandom));
            s.br = s.hl ? 1'b0 : (($urandom % 3) == 0);
            if (mState == M_IDLE && n < 2) s.st = 1'b1;
            expTk = modelTaken(s);
            cycle(s, tk);
            checkVal("rndTaken", int'(tk), int'(expTk));
            modelUpdate(s, expTk);
            checkOutput("rnd", mPc, (mState == M_RUN || mState == M_STALL),
                        (mState == M_DONE), mCarry);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Parametrised program sequencer for the next-generation core. It replaces the hard-wired PC, start/reset coupling, flag registers and branch-condition logic of the current top level.
- Owns the program counter, the registered ALU flags with history depth, the branch-condition evaluation and the run/stall/done handshake.
- Sits between instr_ROM, which is addressed by prog_ctr, and the Control/ALU blocks, which supply decode and flag inputs.

Parameters:
- D, 12, program counter width in bits.
- HIST, 2, depth of the zero-flag history used by the EQ condition (1..4).
- END_PC, 400, PC value that ends the program when no halt instruction executes first.
- RELW, 8, width of the signed relative jump offset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; starts the program from PC 0.
- stall  input  1  hold the PC and flags this cycle (memory wait).
- halt  input  1  decoded halt instruction at the current PC.
- branch  input  1  decoded branch instruction at the current PC.
- cond  input  2  00 EQ, 01 NEG, 10 POS, 11 ALWAYS.
- rel_en  input  1  1 selects a relative branch, 0 an absolute branch.
- target  input  D  absolute branch target (from PC_LUT).
- offset  input  RELW  signed relative offset, two's complement.
- flag_we  input  1  the current instruction updates the flags.
- zero_in  input  1  ALU zero result.
- neg_in  input  1  ALU negative result.
- carry_in  input  1  ALU carry out.
- prog_ctr  output  D  current program counter.
- busy  output  1  the sequencer is in RUN or STALL.
- done  output  1  program finished; held high.
- taken  output  1  the branch at the current PC is taken (combinational).
- carry_q  output  1  registered carry, for the next ALU operation.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prog_ctr=0, done=0, busy=0, carry_q=0, negative flag=0, zero history all 0.
- States:
  - IDLE: start -> RUN, prog_ctr=0, done=0.
  - RUN: stall -> STALL; else, if halt or prog_ctr==END_PC -> DONE; else advance the PC.
  - STALL: !stall -> RUN. PC and flags frozen.
  - DONE: done=1, PC frozen; start -> RUN, prog_ctr=0, done=0, zero history cleared.
- start while in RUN or STALL: restart at PC 0 next cycle. Flags are kept; the zero history is cleared.
- PC update in RUN (one cycle per instruction, no latency bubble):
  - taken and !rel_en: prog_ctr <= target.
  - taken and rel_en: prog_ctr <= prog_ctr + sign-extended offset, modulo 2^D (wraps both ways).
  - otherwise prog_ctr <= prog_ctr + 1, wrapping from 2^D-1 to 0.
- Conditions (taken = branch & state==RUN & !stall & condition):
  - EQ: all HIST entries of the zero history are 1.
  - NEG: the negative flag is 1.
  - POS: the negative flag is 0 and the newest zero entry is 0.
  - ALWAYS: 1.
- Flags:
  - Updated on a RUN cycle with !stall and flag_we.
  - The zero history shifts in zero_in; the negative flag <= neg_in; carry_q <= carry_in.
  - The flags seen by a branch are those registered before the branch cycle, i.e. from earlier instructions only.
- halt and branch in the same cycle: halt wins; the PC does not move.
- stall in the same cycle as halt: the stall wins; halt is re-sampled after the stall clears.
- Inputs other than start and reset are ignored in IDLE and DONE.

Optional Feature:
- Macro: CORE_SEQ_PERF_EN.
- Enabled: adds output cycle_cnt (32 bits) and output branch_cnt (16 bits).
  - cycle_cnt counts clocks in RUN and STALL.
  - branch_cnt counts taken branches.
  - Both saturate at all-ones, clear on start and on reset, and freeze in DONE.
- Disabled: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Basic run: reset low, release, start pulse, no branch, no halt -> prog_ctr counts 0..400; done=1 on the cycle after PC 400, busy=0, PC held at 400.
- Absolute EQ branch (HIST=2):
  - flag_we with zero_in=1 on two consecutive instructions, then branch, cond=00, target=0x020 at PC 5 -> taken=1; next prog_ctr=0x020.
  - Same sequence with a single zero -> taken=0; next prog_ctr=6.
- Relative wrap: PC=3, branch, cond=11, rel_en=1, offset=-5 (0xFB) -> next prog_ctr=0xFFE with D=12.
- Stall: stall high for 3 cycles at PC 10, with flag_we=1 and zero_in toggling -> PC stays 10 and the flags are unchanged; PC=11 one cycle after stall drops.
- Halt vs branch: halt=1 and branch=1, cond=11, at PC 7 -> state DONE, prog_ctr stays 7, done=1. Then a start pulse -> prog_ctr=0, done=0 next cycle.
- Async reset mid-run: reset asserted between clock edges at PC 50 -> prog_ctr=0, busy=0, done=0 immediately. With CORE_SEQ_PERF_EN, cycle_cnt=0 immediately.
